trace_capture: RTL

Synthesisable, parametrised on-chip logic-analyser core: continuously samples a probe bus into a circular buffer, triggers on a masked pattern match or an external pulse, and freezes a window of pre- and post-trigger samples for readout. It replaces the empty vendor ILA stub wherever we need real capture in simulation and on FPGA. Readout goes through a simple synchronous read port that a debug/UART bridge drives.

---
 rtl/trace_capture.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/trace_capture.sv
// trace_capture: on-chip logic-analyser core.
// Samples a probe bus into a circular buffer and triggers on a masked pattern
// match or an external level. After the trigger it freezes a DEPTH-sample
// window, with PRE_TRIG samples before the trigger sample, for synchronous
// readout.
module trace_capture #(
    parameter int PROBE_W  = 64,
    parameter int DEPTH    = 1024,
    parameter int PRE_TRIG = DEPTH / 4
) (
    input  logic                     msoc_clk,
    input  logic                     rstn,
    input  logic [PROBE_W-1:0]       probe,
    input  logic [PROBE_W-1:0]       trig_mask,
    input  logic [PROBE_W-1:0]       trig_value,
    input  logic                     trig_ext,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [PROBE_W-1:0]       rd_data,
    output logic [2:0]               state,
    output logic                     triggered,
    output logic                     done,
    output logic [31:0]              trig_time
);

    localparam int AW = $clog2(DEPTH);

    // Last pre-trigger fill index; unused when PRE_TRIG is 0.
    localparam logic [AW-1:0] PRE_LAST = (PRE_TRIG == 0) ? '0 : AW'(PRE_TRIG - 1);
    // Samples still to be written after the trigger sample.
    localparam logic [AW-1:0] POST_LEN = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW-1:0] PRE_OFF  = AW'(PRE_TRIG);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [31:0]        cycle_cnt;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      fill_cnt;
    logic [AW-1:0]      post_cnt;
    logic [AW-1:0]      trig_addr;
    logic [AW-1:0]      rd_base;
    logic               hit;
    logic               wr_en;
    logic               start;
    logic               fire;

    logic [PROBE_W-1:0] mem [DEPTH];

    assign hit = ((|trig_mask) && (((probe ^ trig_value) & trig_mask) == '0)) || trig_ext;

    assign state   = state_q;
    assign done    = (state_q == ST_DONE);
    assign rd_base = trig_addr - PRE_OFF;

    // Free-running cycle counter used to timestamp the trigger.
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // always_ff block sees the pre-edge values of the others.
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Capture state register.
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and write/trigger strobes; abort overrides arm and hit.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        wr_en   = 1'b0;
        start   = 1'b0;
        fire    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        start   = 1'b1;
                        state_d = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
                    end
                end
                ST_PRE: begin
                    wr_en = 1'b1;
                    if (fill_cnt == PRE_LAST) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    wr_en = 1'b1;
                    if (hit) begin
                        fire    = 1'b1;
                        state_d = (POST_LEN == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    wr_en = 1'b1;
                    if (post_cnt == AW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Write pointer, fill/post counters and trigger bookkeeping.
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            trig_addr <= '0;
            trig_time <= '0;
            triggered <= 1'b0;
        end else if (abort) begin
            triggered <= 1'b0;
        end else begin
            if (start) begin
                wr_ptr    <= '0;
                fill_cnt  <= '0;
                triggered <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (state_q == ST_PRE) begin
                fill_cnt <= fill_cnt + AW'(1);
            end
            if (fire) begin
                trig_addr <= wr_ptr;
                trig_time <= cycle_cnt;
                triggered <= 1'b1;
                post_cnt  <= POST_LEN;
            end
            if (state_q == ST_POST) begin
                post_cnt <= post_cnt - AW'(1);
            end
        end
    end

    // Sample buffer write port.
    always_ff @(posedge msoc_clk) begin
        // NOTE: the buffer has no reset so it maps onto a block RAM; its
        // contents are only meaningful once a capture reaches DONE.
        if (wr_en) begin
            mem[wr_ptr] <= probe;
        end
    end

    // Registered logical read, rotated so index 0 is the oldest sample.
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_base + rd_addr];
        end
    end

endmodule
